// File: rtl/booth_sequential_multiplier.sv
// Multi-cycle signed 32x32 radix-2 Booth multiplier.
// Operands load on writeEnableIn; the result is fetched with readEnableOut after 32 steps.
module booth_sequential_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        writeEnableIn,
  input  logic        readEnableOut,
  output logic [31:0] product,
  output logic        overflow,
  output logic        busy,
  output logic        done,
  output logic        accessError
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [31:0] m_q;
  logic [32:0] h_q, h_d;
  logic [31:0] q_q, q_d;
  logic        q1_q, q1_d;
  logic [4:0]  cnt_q;
  logic [31:0] product_q;
  logic        overflow_q;
  logic        access_error_q;

  logic [32:0] m_ext;
  logic [32:0] sum;
  logic [63:0] result;
  logic        ovf_cand;
  logic        load;
  logic        rd_ok;
  logic        illegal;

  always_comb begin
    m_ext = {m_q[31], m_q};
    unique case ({q_q[0], q1_q})
      2'b01:   sum = h_q + m_ext;
      2'b10:   sum = h_q - m_ext;
      default: sum = h_q;
    endcase
    // Arithmetic right shift of the 66-bit {H, Q, q_1} accumulator.
    h_d  = {sum[32], sum[32:1]};
    q_d  = {sum[0], q_q[31:1]};
    q1_d = q_q[0];

    result   = {h_q[31:0], q_q};
    ovf_cand = ~((&result[63:31]) | ~(|result[63:31]));

    load    = writeEnableIn && (state_q != StCalc);
    rd_ok   = readEnableOut && (state_q == StDone);
    illegal = (writeEnableIn && (state_q == StCalc)) ||
              (readEnableOut && (state_q != StDone));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      m_q            <= '0;
      h_q            <= '0;
      q_q            <= '0;
      q1_q           <= 1'b0;
      cnt_q          <= '0;
      product_q      <= '0;
      overflow_q     <= 1'b0;
      access_error_q <= 1'b0;
    end else begin
      access_error_q <= illegal;
      if (rd_ok) begin
        product_q  <= result[31:0];
        overflow_q <= ovf_cand;
      end
      if (load) begin
        // A write in DONE discards any unread result and restarts.
        m_q     <= a;
        h_q     <= '0;
        q_q     <= b;
        q1_q    <= 1'b0;
        cnt_q   <= '0;
        state_q <= StCalc;
      end else begin
        unique case (state_q)
          StCalc: begin
            h_q   <= h_d;
            q_q   <= q_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q <= StDone;
            end
          end
          StDone: begin
            if (rd_ok) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign product     = product_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q == StCalc);
  assign done        = (state_q == StDone);
  assign accessError = access_error_q;

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Scoreboard bench for booth_sequential_multiplier: expected results are queued on write
// and compared on read.
module tb_booth_sequential_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        writeEnableIn, readEnableOut;
  logic [31:0] product;
  logic        overflow, busy, done, accessError;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  booth_sequential_multiplier dut (
    .clk           (clk),
    .reset         (reset),
    .a             (a),
    .b             (b),
    .writeEnableIn (writeEnableIn),
    .readEnableOut (readEnableOut),
    .product       (product),
    .overflow      (overflow),
    .busy          (busy),
    .done          (done),
    .accessError   (accessError)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {overflow, product} from a plain 64-bit signed multiply.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    longint      r;
    logic [63:0] rv;
    r  = longint'($signed(x)) * longint'($signed(y));
    rv = r;
    return {~((&rv[63:31]) | ~(|rv[63:31])), rv[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_op(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    writeEnableIn = 1'b1;
    tick();
    writeEnableIn = 1'b0;
    exp_q.push_back(model(x, y));
    check_eq("busy_after_write", busy, 1);
    check_eq("done_after_write", done, 0);
  endtask

  // Junk write is injected before edge inject_at+1 when inject_at >= 0.
  task automatic wait_done(input string tag, input int inject_at);
    int cycles = 0;
    while (!done && cycles < 100) begin
      if (cycles == inject_at) begin
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        writeEnableIn = 1'b1;
      end
      tick();
      writeEnableIn = 1'b0;
      cycles++;
      if (inject_at >= 0 && cycles == inject_at + 1) check_eq("calc_write_err", accessError, 1);
      if (inject_at >= 0 && cycles == inject_at + 2) check_eq("calc_write_clr", accessError, 0);
    end
    check_eq({tag, "_latency"}, cycles, 32);
    check_eq({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic pop_check(input string tag);
    logic [32:0] e;
    check_eq({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_product"}, product, e[31:0]);
      check_eq({tag, "_overflow"}, overflow, e[32]);
    end
  endtask

  task automatic read_op(input string tag);
    readEnableOut = 1'b1;
    tick();
    readEnableOut = 1'b0;
    pop_check(tag);
    check_eq({tag, "_done_clr"}, done, 0);
    check_eq({tag, "_no_err"}, accessError, 0);
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y);
    write_op(x, y);
    wait_done(tag, -1);
    read_op(tag);
  endtask

  initial begin
    reset = 1'b1;
    a = '0;
    b = '0;
    writeEnableIn = 1'b0;
    readEnableOut = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_outputs", {product, overflow, busy, done, accessError}, 36'h0);

    // Reference values taken directly from the worked examples.
    run("big", 32'd211819911, 32'd12345);
    check_eq("big_const", {overflow, product}, {1'b1, 32'hD52F_E30F});

    readEnableOut = 1'b1;
    tick();
    readEnableOut = 1'b0;
    check_eq("idle_read_err", accessError, 1);
    check_eq("idle_read_hold", {overflow, product}, {1'b1, 32'hD52F_E30F});
    tick();
    check_eq("idle_read_clr", accessError, 0);

    run("neg_pos", 32'hFFFF_F7C1, 32'h0000_007D);
    check_eq("neg_pos_const", {overflow, product}, {1'b0, 32'hFFFB_F93D});
    run("pos_neg", 32'd502, 32'hFFFF_FFFC);
    check_eq("pos_neg_const", {overflow, product}, {1'b0, 32'hFFFF_F828});
    run("min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("min_m1_const", {overflow, product}, {1'b1, 32'h8000_0000});
    run("min_p1", 32'h8000_0000, 32'h0000_0001);
    check_eq("min_p1_const", {overflow, product}, {1'b0, 32'h8000_0000});

    for (int i = 0; i < 4; i++) run("rand", $urandom(), $urandom());

    // Illegal write mid-computation must not disturb the running multiply.
    write_op(32'd123456, 32'hFFFF_FF85);
    wait_done("calc_write", 10);
    read_op("calc_write");

    // Back-to-back: read the old result and load 7 x 6 on the same edge.
    write_op(32'd1000, 32'd999);
    wait_done("b2b_first", -1);
    a = 32'd7;
    b = 32'd6;
    readEnableOut = 1'b1;
    writeEnableIn = 1'b1;
    tick();
    readEnableOut = 1'b0;
    writeEnableIn = 1'b0;
    pop_check("b2b_first");
    check_eq("b2b_no_err", accessError, 0);
    check_eq("b2b_busy", busy, 1);
    exp_q.push_back(model(32'd7, 32'd6));
    wait_done("b2b_second", -1);
    read_op("b2b_second");
    check_eq("b2b_const", product, 32'd42);

    // Reset mid-CALC with a strobe present: all outputs clear, no error raised.
    write_op(32'd5, 32'd9);
    for (int i = 0; i < 19; i++) tick();
    check_eq("pre_rst_busy", busy, 1);
    reset = 1'b1;
    writeEnableIn = 1'b1;
    tick();
    reset = 1'b0;
    writeEnableIn = 1'b0;
    exp_q.delete();
    check_eq("mid_rst_outputs", {product, overflow, busy, done, accessError}, 36'h0);
    tick();
    check_eq("mid_rst_idle", {busy, done, accessError}, 3'b000);

    run("zero", 32'd0, 32'd0);
    check_eq("zero_const", {overflow, product}, 33'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
